// File: rtl/shift_reg_seq_if.sv
// ---------------------------------------------------------------------------
// shift_reg_seq_if
// Bundle between a word-producing master and the shift_reg_seq frame
// sequencer.
//   in_valid   master -> seq   word offered on in_data
//   in_data    master -> seq   WIDTH-bit word to serialize
//   in_ready   seq -> master   sequencer can accept a word this cycle
//   abort      master -> seq   synchronous frame cancel
//   pi         seq -> master   serial bit towards the shift register
//   shift_en   seq -> master   pi carries a valid frame bit this cycle
//   busy       seq -> master   frame in progress
//   frame_done seq -> master   one-cycle pulse after the last frame bit
// Modports: master (word producer / observer), slave (the sequencer).
// ---------------------------------------------------------------------------
interface shift_reg_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             abort;
  logic             pi;
  logic             shift_en;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, pi, shift_en, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, pi, shift_en, busy, frame_done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// ---------------------------------------------------------------------------
// shift_reg_seq
// Frame sequencer: accepts a parallel word on a valid/ready handshake and
// presents it MSB first, one bit per clock, on pi qualified by shift_en.
// frame_done pulses for one cycle after the last bit of each frame.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  shift_reg_seq_if.slave (in_valid/in_data/in_ready/abort in,
//        pi/shift_en/busy/frame_done out)
//
// Optional feature macro: SHIFT_REG_SEQ_PARITY_EN
//   defined   -> a PARITY state appends an even-parity bit to every frame
//                (WIDTH+1 shift_en cycles per frame)
//   undefined -> frames are exactly WIDTH shift_en cycles
// ---------------------------------------------------------------------------
module shift_reg_seq #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  shift_reg_seq_if.slave bus
);

  localparam int              CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SHIFT_REG_SEQ_PARITY_EN
    ST_PARITY = 2'd3,
`endif
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] hold_q,  hold_d;

  logic ready_state;
  logic accept;

  // The sequencer can take a word while idle or in the DONE cycle (which
  // gives back-to-back frames). rst gates it so in_ready is low during reset.
  always_comb begin
    ready_state = (state_q == ST_IDLE) || (state_q == ST_DONE);
  end

  assign bus.in_ready = rst & ready_state;
  assign accept       = bus.in_valid & bus.in_ready & ~bus.abort;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic (state, bit counter, holding register)
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
`ifdef SHIFT_REG_SEQ_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SHIFT_REG_SEQ_PARITY_EN
      ST_PARITY: begin
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = accept ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // accept already excludes abort, so a new word is only loaded when the
    // frame is genuinely starting.
    if (accept) begin
      cnt_d  = CNT_TOP;
      hold_d = bus.in_data;
    end

    // abort wins over everything; bits already shifted stay shifted.
    if (bus.abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode, purely from registered state
  // -------------------------------------------------------------------------
  always_comb begin
    bus.pi         = 1'b0;
    bus.shift_en   = 1'b0;
    bus.busy       = 1'b0;
    bus.frame_done = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        bus.pi       = hold_q[cnt_q];
        bus.shift_en = 1'b1;
        bus.busy     = 1'b1;
      end
`ifdef SHIFT_REG_SEQ_PARITY_EN
      ST_PARITY: begin
        bus.pi       = ^hold_q;  // even parity over the data word
        bus.shift_en = 1'b1;
        bus.busy     = 1'b1;
      end
`endif
      ST_DONE: begin
        bus.frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_seq
// Directed bench for shift_reg_seq (WIDTH = 16). Works with and without
// SHIFT_REG_SEQ_PARITY_EN; parity-specific expectations are guarded.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_shift_reg_seq;

  localparam int WIDTH = 16;
`ifdef SHIFT_REG_SEQ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = WIDTH + PAR;

  logic clk = 1'b0;
  logic rst;

  int assertions = 0;
  int failures   = 0;

  shift_reg_seq_if #(.WIDTH(WIDTH)) bus ();

  shift_reg_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.abort    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      assertions++;
      if ({bus.pi, bus.shift_en, bus.busy, bus.frame_done, bus.in_ready} !== 5'b00000) begin
        failures++;
        $display("FAIL reset_outputs: got pi/se/busy/done/rdy=%b expected 00000",
                 {bus.pi, bus.shift_en, bus.busy, bus.frame_done, bus.in_ready});
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      assertions++;
      if ({bus.in_ready, bus.busy, bus.shift_en, bus.frame_done} !== 4'b1000) begin
        failures++;
        $display("FAIL reset_release cycle %0d: got rdy/busy/se/done=%b expected 1000",
                 i, {bus.in_ready, bus.busy, bus.shift_en, bus.frame_done});
      end
    end
    $display("test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_serialize;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] q_model;
    word    = 16'hA5C3;  // bits MSB first: 1010 0101 1100 0011
    q_model = '0;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    assertions++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL serialize_ready: got %b expected 1", bus.in_ready);
    end
    step();  // accept edge E
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      assertions++;
      if ({bus.pi, bus.shift_en, bus.busy, bus.frame_done} !== {word[WIDTH-1-i], 3'b110}) begin
        failures++;
        $display("FAIL serialize_bit %0d: got pi/se/busy/done=%b expected %b",
                 i, {bus.pi, bus.shift_en, bus.busy, bus.frame_done}, {word[WIDTH-1-i], 3'b110});
      end
      q_model = {q_model[WIDTH-2:0], bus.pi};
      step();
    end
`ifdef SHIFT_REG_SEQ_PARITY_EN
    assertions++;
    if ({bus.pi, bus.shift_en} !== 2'b01) begin  // A5C3 has eight ones
      failures++;
      $display("FAIL serialize_parity: got pi/se=%b expected 01", {bus.pi, bus.shift_en});
    end
    step();
`endif
    assertions++;
    if ({bus.frame_done, bus.shift_en, bus.busy, bus.pi} !== 4'b1000) begin
      failures++;
      $display("FAIL serialize_done: got done/se/busy/pi=%b expected 1000",
               {bus.frame_done, bus.shift_en, bus.busy, bus.pi});
    end
    assertions++;
    if (q_model !== 16'hA5C3) begin
      failures++;
      $display("FAIL serialize_q: got %h expected a5c3", q_model);
    end
    step();
    assertions++;
    if ({bus.frame_done, bus.in_ready, bus.busy} !== 3'b010) begin
      failures++;
      $display("FAIL serialize_after: got done/rdy/busy=%b expected 010",
               {bus.frame_done, bus.in_ready, bus.busy});
    end
    $display("test_serialize word=%h q=%h", word, q_model);
  endtask

`ifdef SHIFT_REG_SEQ_PARITY_EN
  // -------------------------------------------------------------------------
  task automatic test_parity;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      assertions++;
      if ({bus.pi, bus.shift_en} !== {(i == WIDTH - 1), 1'b1}) begin
        failures++;
        $display("FAIL parity_data %0d: got pi/se=%b expected %b",
                 i, {bus.pi, bus.shift_en}, {(i == WIDTH - 1), 1'b1});
      end
      step();
    end
    assertions++;
    if ({bus.pi, bus.shift_en, bus.frame_done} !== 3'b110) begin
      failures++;
      $display("FAIL parity_bit: got pi/se/done=%b expected 110",
               {bus.pi, bus.shift_en, bus.frame_done});
    end
    step();
    assertions++;
    if ({bus.frame_done, bus.shift_en} !== 2'b10) begin
      failures++;
      $display("FAIL parity_done: got done/se=%b expected 10", {bus.frame_done, bus.shift_en});
    end
    step();
    $display("test_parity word=0001");
  endtask
`endif

  // -------------------------------------------------------------------------
  task automatic test_back_to_back;
    logic [WIDTH-1:0] w1;
    logic             exp_bit;
    int               pulses;
    w1     = 16'h1234;
    pulses = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w1;
    step();                 // first word accepted
    bus.in_data  = 16'hFFFF; // valid stays high; ignored until DONE
    for (int i = 0; i < FRAME; i++) begin
      exp_bit = (i < WIDTH) ? w1[WIDTH-1-i] : 1'b1;  // 0x1234 has five ones
      assertions++;
      if ({bus.pi, bus.shift_en, bus.in_ready} !== {exp_bit, 2'b10}) begin
        failures++;
        $display("FAIL b2b_first %0d: got pi/se/rdy=%b expected %b",
                 i, {bus.pi, bus.shift_en, bus.in_ready}, {exp_bit, 2'b10});
      end
      if (bus.frame_done === 1'b1) pulses++;
      step();
    end
    assertions++;
    if ({bus.frame_done, bus.in_ready, bus.shift_en} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_done1: got done/rdy/se=%b expected 110",
               {bus.frame_done, bus.in_ready, bus.shift_en});
    end
    if (bus.frame_done === 1'b1) pulses++;
    step();                 // second word accepted in the DONE cycle
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < FRAME; i++) begin
      exp_bit = (i < WIDTH) ? 1'b1 : 1'b0;  // 0xFFFF has even parity
      assertions++;
      if ({bus.pi, bus.shift_en} !== {exp_bit, 1'b1}) begin
        failures++;
        $display("FAIL b2b_second %0d: got pi/se=%b expected %b",
                 i, {bus.pi, bus.shift_en}, {exp_bit, 1'b1});
      end
      if (bus.frame_done === 1'b1) pulses++;
      step();
    end
    if (bus.frame_done === 1'b1) pulses++;
    step();
    assertions++;
    if ({bus.busy, bus.frame_done, bus.in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_idle: got busy/done/rdy=%b expected 001",
               {bus.busy, bus.frame_done, bus.in_ready});
    end
    assertions++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d expected 2", pulses);
    end
    $display("test_back_to_back words=1234,ffff pulses=%0d", pulses);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_abort;
    int pulses;
    pulses = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hB38E;  // 1011 0011 1000 1110
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    assertions++;
    if ({bus.shift_en, bus.pi} !== 2'b10) begin  // 6th bit (bit 10) is 0
      failures++;
      $display("FAIL abort_sixth: got se/pi=%b expected 10", {bus.shift_en, bus.pi});
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    assertions++;
    if ({bus.shift_en, bus.busy, bus.frame_done, bus.in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_idle: got se/busy/done/rdy=%b expected 0001",
               {bus.shift_en, bus.busy, bus.frame_done, bus.in_ready});
    end
    for (int i = 0; i < WIDTH + 3; i++) begin
      step();
      if (bus.frame_done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    assertions++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d busy/done cycles expected 0", pulses);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.abort    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    assertions++;
    if ({bus.busy, bus.shift_en, bus.in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL abort_noaccept: got busy/se/rdy=%b expected 001",
               {bus.busy, bus.shift_en, bus.in_ready});
    end
    step();
    assertions++;
    if ({bus.busy, bus.shift_en} !== 2'b00) begin
      failures++;
      $display("FAIL abort_noaccept2: got busy/se=%b expected 00", {bus.busy, bus.shift_en});
    end
    $display("test_abort done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_frame;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] q_model;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    assertions++;
    if ({bus.shift_en, bus.pi} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_before: got se/pi=%b expected 11", {bus.shift_en, bus.pi});
    end
    rst = 1'b0;
    #1;
    assertions++;
    if ({bus.pi, bus.shift_en, bus.busy, bus.frame_done, bus.in_ready} !== 5'b00000) begin
      failures++;
      $display("FAIL rstmid_immediate: got pi/se/busy/done/rdy=%b expected 00000",
               {bus.pi, bus.shift_en, bus.busy, bus.frame_done, bus.in_ready});
    end
    step();
    step();
    rst = 1'b1;
    step();
    assertions++;
    if ({bus.in_ready, bus.busy, bus.shift_en} !== 3'b100) begin
      failures++;
      $display("FAIL rstmid_release: got rdy/busy/se=%b expected 100",
               {bus.in_ready, bus.busy, bus.shift_en});
    end
    word    = 16'h00FF;
    q_model = '0;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      assertions++;
      if ({bus.pi, bus.shift_en} !== {(i >= 8), 1'b1}) begin
        failures++;
        $display("FAIL rstmid_bit %0d: got pi/se=%b expected %b",
                 i, {bus.pi, bus.shift_en}, {(i >= 8), 1'b1});
      end
      q_model = {q_model[WIDTH-2:0], bus.pi};
      step();
    end
    for (int i = 0; i < PAR; i++) step();  // 0x00FF parity bit is 0
    assertions++;
    if ({bus.frame_done, q_model} !== {1'b1, 16'h00FF}) begin
      failures++;
      $display("FAIL rstmid_frame: got done=%b q=%h expected done=1 q=00ff",
               bus.frame_done, q_model);
    end
    step();
    $display("test_reset_mid_frame word=%h q=%h", word, q_model);
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_serialize();
`ifdef SHIFT_REG_SEQ_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Frame sequencer for the serial-in `shift_register` datapath. Accepts a parallel word on a valid/ready handshake and presents it one bit per clock on a serial output, MSB first, with a qualifying shift-enable. It signals frame completion with a one-cycle pulse. Sits between a word-producing master and one `shift_register` instance (its `pi` input); after a frame, the register's `q` holds the word.

## Interface
- `WIDTH`, 16, frame data width in bits (≥2); bit counter width is derived internally.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  master offers `in_data`.
- `in_data`  in  WIDTH  word to serialize.
- `in_ready`  out  1  sequencer can accept a word this cycle.
- `abort`  in  1  synchronous frame cancel.
- `pi`  out  1  serial bit to shift register.
- `shift_en`  out  1  `pi` is a valid frame bit this cycle.
- `busy`  out  1  frame in progress (SHIFT or PARITY).
- `frame_done`  out  1  one-cycle pulse after last bit of a frame.

## Operation
- States: IDLE, SHIFT, PARITY (macro only), DONE.
- Holding register `hold[WIDTH-1:0]` captures `in_data` on accept; bit counter `cnt`.
- Accept = `in_valid & in_ready & ~abort`. `in_ready` = 1 in IDLE and DONE, 0 otherwise, and 0 while `rst` is low.
- IDLE: on accept → SHIFT, `cnt` = WIDTH-1. Otherwise stay.
- SHIFT: `pi` = `hold[cnt]`, `shift_en` = 1, `busy` = 1. `cnt` decrements each cycle. At `cnt` = 0 → PARITY (macro) or DONE.
- PARITY: `pi` = XOR of `hold` (even parity), `shift_en` = 1, `busy` = 1; → DONE.
- DONE: `frame_done` = 1 for this cycle only. On accept → SHIFT (back-to-back); else → IDLE.
- Outside SHIFT/PARITY: `pi` = 0, `shift_en` = 0.
- `abort` high at an edge in any state → IDLE. It does not cause `frame_done` and takes priority over a simultaneous `in_valid`. Partial bits already shifted are not retracted.
- `in_valid` during SHIFT/PARITY is ignored (not accepted, not queued). `in_data` is sampled only at accept.

## Timing
- Reset (`rst` low, any time including mid-frame): state IDLE, `cnt` = 0, `hold` = 0. Outputs: `pi` = 0, `shift_en` = 0, `busy` = 0, `frame_done` = 0, `in_ready` = 0. `in_ready` = 1 from the first cycle after release.
- Accept at edge E: bit WIDTH-1 presented in cycle after E, bit 0 in cycle E+WIDTH. `frame_done` in cycle E+WIDTH+1 (E+WIDTH+2 with parity).
- Throughput: one frame per WIDTH+1 cycles (WIDTH+2 with parity) when `in_valid` is held continuously.
- All outputs are decoded from registered state/`hold`/`cnt`; there is no combinational path from inputs to outputs except `in_ready` gating by `rst`.

## Configuration
- `SHIFT_REG_SEQ_PARITY_EN` defined: PARITY state compiled in. Each frame is WIDTH+1 `shift_en` cycles, with the last bit being even parity of the word.
- Undefined: no PARITY state. Frame is exactly WIDTH `shift_en` cycles; SHIFT goes directly to DONE.

## Test plan
- Reset release, `in_valid` = 0 → all outputs 0 during reset. `in_ready` = 1 on the first cycle after release, and stays IDLE.
- WIDTH=16, accept 0xA5C3 at edge E → `pi` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with `shift_en` = 1 on cycles E+1..E+16. `frame_done` = 1 only in cycle E+17 (no macro). Downstream `q` = 0xA5C3.
- Parity build: accept 0x0001 → 16 data bits, then `pi` = 1 in a 17th `shift_en` cycle, then `frame_done`. Accept 0xA5C3 → parity bit 0.
- `in_valid` held with 0x1234 then 0xFFFF → second word accepted in the DONE cycle. Its first bit follows with no idle gap, and `frame_done` pulses once per word.
- `abort` at 6th shift cycle → IDLE next edge, `shift_en` = 0, no `frame_done`, `in_ready` = 1. `abort` with `in_valid` in IDLE → no accept.
- `rst` low mid-frame at bit 8 → immediate `pi`/`shift_en`/`busy` = 0. After release, a new frame of 0x00FF serializes correctly from MSB.
